// File: rtl/reg_timer_slave.sv
// rtl/reg_timer_slave.sv - register-mapped multi-channel low/high timer; optional irq output under REG_TIMER_IRQ_EN
module reg_timer_slave #(
    parameter int NCH = 2,
    parameter int DW  = 32,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [1:0]     cmd,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [DW-1:0]  cmd_data_m2s,
    output logic [DW-1:0]  cmd_data_s2m,
    output logic [NCH-1:0] loc_out
`ifdef REG_TIMER_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int          CW   = AW - 2;
    localparam logic [AW:0] NREG = (AW+1)'(NCH * 4);

    typedef enum logic [1:0] {S_OFF, S_LOW, S_HIGH} state_t;

    logic           is_wr, is_rd, addr_ok;
    logic [CW-1:0]  ch_sel;
    logic [NCH-1:0] en_a, out_a, irq_a;
    logic [DW-1:0]  low_a  [NCH];
    logic [DW-1:0]  high_a [NCH];
    logic [DW-1:0]  rd_val, rdata_q;

    assign is_wr   = (cmd == 2'b01);
    assign is_rd   = (cmd == 2'b10);
    assign addr_ok = ({1'b0, cmd_addr} < NREG);
    assign ch_sel  = cmd_addr[AW-1:2];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic          wr_hit, go_low, go_high;
        logic          en_q, en_d, out_q, out_d;
        logic [DW-1:0] low_q, low_d, high_q, high_d, cnt_q, cnt_d;
        logic [DW-1:0] first_t, second_t;
        state_t        state_q, state_d;

        assign wr_hit = is_wr && addr_ok && (ch_sel == CW'(c));

        always_comb begin
            en_d   = en_q;
            low_d  = low_q;
            high_d = high_q;
            if (wr_hit) begin
                case (cmd_addr[1:0])
                    2'd0:    en_d   = cmd_data_m2s[0];
                    2'd1:    low_d  = cmd_data_m2s;
                    2'd2:    high_d = cmd_data_m2s;
                    default: ;
                endcase
            end

            go_low  = 1'b0;
            go_high = 1'b0;
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF:   go_low = 1'b1;
                // cnt 0 in LOW only happens with both timers 0: keep re-evaluating entry
                S_LOW:   if (cnt_q == DW'(1)) go_high = 1'b1;
                         else if (cnt_q == '0) go_low = 1'b1;
                         else cnt_d = cnt_q - DW'(1);
                S_HIGH:  if (cnt_q <= DW'(1)) go_low = 1'b1;
                         else cnt_d = cnt_q - DW'(1);
                default: go_low = 1'b1;
            endcase

            // The counter is the shadow: timers are sampled only at phase entry
            first_t  = go_high ? high_q : low_q;
            second_t = go_high ? low_q  : high_q;
            if (go_low || go_high) begin
                if (first_t != '0) begin
                    state_d = go_high ? S_HIGH : S_LOW;
                    cnt_d   = first_t;
                end else if (second_t != '0) begin
                    state_d = go_high ? S_LOW : S_HIGH;
                    cnt_d   = second_t;
                end else begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            end

            if (!en_d) begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
            out_d = (state_d == S_HIGH);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                en_q    <= 1'b0;
                low_q   <= '0;
                high_q  <= '0;
                cnt_q   <= '0;
                state_q <= S_OFF;
                out_q   <= 1'b0;
            end else begin
                en_q    <= en_d;
                low_q   <= low_d;
                high_q  <= high_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
                out_q   <= out_d;
            end
        end

`ifdef REG_TIMER_IRQ_EN
        logic irq_q, irq_d;

        always_comb begin
            irq_d = irq_q;
            if (wr_hit && (cmd_addr[1:0] == 2'd3) && cmd_data_m2s[1]) irq_d = 1'b0;
            if (out_d && !out_q) irq_d = 1'b1;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) irq_q <= 1'b0;
            else       irq_q <= irq_d;
        end

        assign irq_a[c] = irq_q;
`else
        assign irq_a[c] = 1'b0;
`endif

        assign en_a[c]   = en_q;
        assign out_a[c]  = out_q;
        assign low_a[c]  = low_q;
        assign high_a[c] = high_q;
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (addr_ok && (ch_sel == CW'(c))) begin
                case (cmd_addr[1:0])
                    2'd0:    rd_val = {{(DW-1){1'b0}}, en_a[c]};
                    2'd1:    rd_val = low_a[c];
                    2'd2:    rd_val = high_a[c];
                    default: rd_val = {{(DW-2){1'b0}}, irq_a[c], out_a[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      rdata_q <= '0;
        else if (is_rd) rdata_q <= rd_val;
    end

    assign cmd_data_s2m = rdata_q;
    assign loc_out      = out_a;
`ifdef REG_TIMER_IRQ_EN
    assign irq = |irq_a;
`endif

endmodule

// File: tb/tb_reg_timer_slave.sv
// tb/tb_reg_timer_slave.sv - self-checking bench for reg_timer_slave against a phase/deadline reference model
module tb_reg_timer_slave;
    localparam int NCH  = 2;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int NREG = NCH * 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [1:0]     cmd;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_data_m2s;
    logic [DW-1:0]  cmd_data_s2m;
    logic [NCH-1:0] loc_out;
`ifdef REG_TIMER_IRQ_EN
    logic           irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_timer_slave #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd          (cmd),
        .cmd_addr     (cmd_addr),
        .cmd_data_m2s (cmd_data_m2s),
        .cmd_data_s2m (cmd_data_s2m),
        .loc_out      (loc_out)
`ifdef REG_TIMER_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    // Reference: each channel is in a phase (0 off, 1 low, 2 high) that ends at an absolute cycle
    logic          m_en   [NCH];
    logic [DW-1:0] m_low  [NCH];
    logic [DW-1:0] m_high [NCH];
    int            m_ph   [NCH];
    longint        m_end  [NCH];
    bit            m_hold [NCH];
    logic          m_out  [NCH];
    logic          m_irq  [NCH];
    logic [DW-1:0] m_rd;
    longint        cyc = 0;

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 1'b0; m_low[c] = '0; m_high[c] = '0; m_ph[c] = 0;
            m_end[c] = 0; m_hold[c] = 1'b0; m_out[c] = 1'b0; m_irq[c] = 1'b0;
        end
        m_rd = '0;
    endfunction

    function automatic logic [DW-1:0] m_reg(int a);
        if (a >= NREG) return '0;
        case (a % 4)
            0:       return {{(DW-1){1'b0}}, m_en[a/4]};
            1:       return m_low[a/4];
            2:       return m_high[a/4];
            default: return {{(DW-2){1'b0}}, m_irq[a/4], m_out[a/4]};
        endcase
    endfunction

    function automatic void m_enter(int c, int want);
        longint dw, dot;
        dw  = (want == 2) ? longint'(m_high[c]) : longint'(m_low[c]);
        dot = (want == 2) ? longint'(m_low[c])  : longint'(m_high[c]);
        m_hold[c] = 1'b0;
        if (dw != 0) begin
            m_ph[c] = want; m_end[c] = cyc + dw;
        end else if (dot != 0) begin
            m_ph[c] = 3 - want; m_end[c] = cyc + dot;
        end else begin
            m_ph[c] = 1; m_hold[c] = 1'b1; m_end[c] = cyc + 1;
        end
    endfunction

    function automatic void m_edge(logic [1:0] k, int a, logic [DW-1:0] d);
        logic wr, en_new, old_out;
        cyc++;
        if (k == 2'b10) m_rd = m_reg(a);
        for (int c = 0; c < NCH; c++) begin
            wr      = (k == 2'b01) && (a < NREG) && (a / 4 == c);
            en_new  = (wr && a % 4 == 0) ? d[0] : m_en[c];
            old_out = m_out[c];
            if (!en_new) begin
                m_ph[c] = 0; m_hold[c] = 1'b0;
            end else if (m_ph[c] == 0) begin
                m_enter(c, 1);
            end else if (cyc == m_end[c]) begin
                m_enter(c, (m_hold[c] || m_ph[c] == 2) ? 1 : 2);
            end
            m_out[c] = (m_ph[c] == 2);
`ifdef REG_TIMER_IRQ_EN
            if (wr && a % 4 == 3 && d[1]) m_irq[c] = 1'b0;
            if (m_out[c] && !old_out) m_irq[c] = 1'b1;
`endif
            m_en[c] = en_new;
            if (wr && a % 4 == 1) m_low[c]  = d;
            if (wr && a % 4 == 2) m_high[c] = d;
        end
    endfunction

    function automatic logic [NCH-1:0] m_loc();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_out[c];
        return r;
    endfunction

    function automatic logic m_irq_any();
        logic r = 1'b0;
        for (int c = 0; c < NCH; c++) r = r | m_irq[c];
        return r;
    endfunction

    task automatic tick(input logic [1:0] k, input int a, input logic [DW-1:0] d);
        cmd = k; cmd_addr = AW'(a); cmd_data_m2s = d;
        @(posedge clk);
        m_edge(k, a, d);
        #1;
        cmd = 2'b00;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd = 2'b00; cmd_addr = '0; cmd_data_m2s = '0;
        m_reset();
        #3;
        total++; if (loc_out !== '0) begin bad++; $display("FAIL reset_loc got=%b exp=0", loc_out); end
        total++; if (cmd_data_s2m !== '0) begin bad++; $display("FAIL reset_s2m got=%h exp=0", cmd_data_s2m); end
`ifdef REG_TIMER_IRQ_EN
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
        #9;
        rstn = 1'b1;
        for (int a = 0; a < NREG + 2; a++) begin
            tick(2'b10, a, '0);
            total++; if (cmd_data_s2m !== '0) begin bad++; $display("FAIL reset_read a=%0d got=%h exp=0", a, cmd_data_s2m); end
            total++; if (loc_out !== '0) begin bad++; $display("FAIL reset_read_loc a=%0d got=%b exp=0", a, loc_out); end
        end
    endtask

    task automatic test_basic();
        logic e;
        tick(2'b01, 1, 3);
        tick(2'b01, 2, 2);
        for (int i = 0; i < 15; i++) begin
            if (i == 0) tick(2'b01, 0, 32'h1);
            else        tick(2'b10, 3, '0);
            e = ((i % 5) >= 3);
            total++;
            if (loc_out[0] !== e || loc_out !== m_loc()) begin
                bad++; $display("FAIL basic_loc i=%0d got=%b exp=%b/%b", i, loc_out, e, m_loc());
            end
            if (i > 0) begin
                e = (((i - 1) % 5) >= 3);
                total++;
                if (cmd_data_s2m !== m_rd || cmd_data_s2m[0] !== e) begin
                    bad++; $display("FAIL basic_status i=%0d got=%h exp=%h", i, cmd_data_s2m, m_rd);
                end
            end
        end
    endtask

    task automatic test_midphase();
        logic e;
        tick(2'b01, 5, 4);
        tick(2'b01, 6, 4);
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      tick(2'b01, 4, 32'h1);
            else if (i == 1) tick(2'b01, 6, 32'h1);
            else             tick(2'b00, 0, '0);
            e = ((i % 5) == 4);
            total++;
            if (loc_out[1] !== e || loc_out !== m_loc()) begin
                bad++; $display("FAIL midphase_loc i=%0d got=%b exp=%b/%b", i, loc_out, e, m_loc());
            end
        end
    endtask

    task automatic test_zero_timers();
        tick(2'b01, 0, '0);
        tick(2'b01, 1, '0);
        tick(2'b01, 2, 5);
        for (int i = 0; i < 12; i++) begin
            if (i == 0) tick(2'b01, 0, 32'h1);
            else        tick(2'b00, 0, '0);
            total++;
            if (loc_out[0] !== 1'b1 || loc_out !== m_loc()) begin
                bad++; $display("FAIL low0_loc i=%0d got=%b exp=1", i, loc_out);
            end
        end
        tick(2'b01, 2, '0);
        for (int j = 0; j < 10; j++) begin
            tick(2'b00, 0, '0);
            total++;
            if (loc_out !== m_loc() || (j >= 5 && loc_out[0] !== 1'b0)) begin
                bad++; $display("FAIL both0_loc j=%0d got=%b exp=%b", j, loc_out, m_loc());
            end
        end
        tick(2'b01, 2, 5);
        tick(2'b00, 0, '0);
        tick(2'b00, 0, '0);
        total++; if (loc_out[0] !== 1'b1) begin bad++; $display("FAIL resume_high got=%b exp=1", loc_out[0]); end
        tick(2'b01, 0, '0);
        total++;
        if (loc_out[0] !== 1'b0 || loc_out !== m_loc()) begin
            bad++; $display("FAIL en_off_loc got=%b exp=0", loc_out[0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] held;
        tick(2'b01, NREG, 32'hDEAD);
        tick(2'b10, NREG, '0);
        total++; if (cmd_data_s2m !== '0) begin bad++; $display("FAIL oob_read got=%h exp=0", cmd_data_s2m); end
        for (int a = 0; a < NREG; a++) begin
            tick(2'b10, a, '0);
            total++; if (cmd_data_s2m !== m_rd) begin bad++; $display("FAIL oob_regs a=%0d got=%h exp=%h", a, cmd_data_s2m, m_rd); end
        end
        held = m_rd;
        tick(2'b11, 1, 32'h7);
        total++; if (cmd_data_s2m !== held) begin bad++; $display("FAIL rsv_hold got=%h exp=%h", cmd_data_s2m, held); end
        tick(2'b10, 1, '0);
        total++; if (cmd_data_s2m !== m_rd) begin bad++; $display("FAIL rsv_reg got=%h exp=%h", cmd_data_s2m, m_rd); end
    endtask

`ifdef REG_TIMER_IRQ_EN
    task automatic test_irq();
        logic e;
        tick(2'b01, 0, '0);
        tick(2'b01, 4, '0);
        tick(2'b01, 3, 32'h2);
        tick(2'b01, 7, 32'h2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", irq); end
        tick(2'b01, 1, 2);
        tick(2'b01, 2, 2);
        for (int i = 0; i < 13; i++) begin
            if (i == 0)                tick(2'b01, 0, 32'h1);
            else if (i == 4 || i == 10) tick(2'b01, 3, 32'h2);
            else                       tick(2'b00, 0, '0);
            e = (i >= 2 && i < 4) || (i >= 6);
            total++;
            if (irq !== e || irq !== m_irq_any()) begin
                bad++; $display("FAIL irq_seq i=%0d got=%b exp=%b", i, irq, e);
            end
        end
    endtask
`endif

    task automatic test_random();
        int r, a;
        logic [1:0] k;
        logic [DW-1:0] d;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            k = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a = $urandom_range(0, NREG + 1);
            d = (a % 4 == 1 || a % 4 == 2) ? DW'($urandom_range(0, 6)) : DW'($urandom);
            tick(k, a, d);
            total++; if (loc_out !== m_loc()) begin bad++; $display("FAIL rand_loc i=%0d got=%b exp=%b", i, loc_out, m_loc()); end
            total++; if (cmd_data_s2m !== m_rd) begin bad++; $display("FAIL rand_s2m i=%0d got=%h exp=%h", i, cmd_data_s2m, m_rd); end
`ifdef REG_TIMER_IRQ_EN
            total++; if (irq !== m_irq_any()) begin bad++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_irq_any()); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        tick(2'b01, 1, 2);
        tick(2'b01, 2, 3);
        tick(2'b01, 0, 32'h1);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(2'b10, 1, '0);
            seen = (loc_out[0] === 1'b1);
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_mid_wait got=0 exp=high within 10 cycles"); end
        #2;
        rstn = 1'b0;
        #1;
        m_reset();
        total++; if (loc_out !== '0) begin bad++; $display("FAIL rst_mid_loc got=%b exp=0", loc_out); end
        total++; if (cmd_data_s2m !== '0) begin bad++; $display("FAIL rst_mid_s2m got=%h exp=0", cmd_data_s2m); end
        @(negedge clk);
        rstn = 1'b1;
        tick(2'b10, 1, '0);
        total++; if (cmd_data_s2m !== '0) begin bad++; $display("FAIL rst_mid_low got=%h exp=0", cmd_data_s2m); end
        tick(2'b10, 0, '0);
        total++; if (cmd_data_s2m !== '0 || loc_out !== '0) begin
            bad++; $display("FAIL rst_mid_ctrl got=%h/%b exp=0", cmd_data_s2m, loc_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midphase();
        test_zero_timers();
        test_out_of_range();
`ifdef REG_TIMER_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
